// File: rtl/memmode_pkg.sv
// memmode_pkg: shared types and constants for the memory-mode selector.
//   guard_state_e : break-before-make sequencer states
//   *_BIT         : bit positions inside the ZX-Uno mode register
//   mem_ctl_t     : bundle of the four single-bit memory strobes
//   PARK_CTL      : strobe values while parked
//   PARK_HI_TOP   : top two bits of the default parked SRAM high address
package memmode_pkg;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_GUARD  = 1'b1
    } guard_state_e;

    localparam int LOCK_BIT = 7;
    localparam int FBEN_BIT = 6;
    localparam int BUSY_BIT = 5;

    typedef struct packed {
        logic zxromcs;
        logic eeprom_oe_n;
        logic sram_oe_n;
        logic sram_write_n;
    } mem_ctl_t;

    localparam mem_ctl_t PARK_CTL = '{
        zxromcs:      1'b0,
        eeprom_oe_n:  1'b1,
        sram_oe_n:    1'b1,
        sram_write_n: 1'b1
    };

    localparam logic [1:0] PARK_HI_TOP = 2'b11;

endpackage

// File: rtl/memmode_guard.sv
// memmode_guard: break-before-make sequencer. Holds the memory strobes parked
// for GUARD cycles after every change of the active paging source.
//   clk        in  system clock
//   mrst       in  synchronous active-high reset
//   req_change in  accepted mode write that needs a (re)started guard window
//   load_mode  out copy mode_req into mode_cur on this edge
//   busy       out guard window in progress (outputs parked)
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_ACTIVE | outputs follow the current source
// ST_GUARD  | outputs parked, cnt_q counts down to 0 then hands over
module memmode_guard
    import memmode_pkg::*;
#(
    parameter int GUARD = 2
) (
    input  logic clk,
    input  logic mrst,
    input  logic req_change,
    output logic load_mode,
    output logic busy
);

    localparam logic [3:0] CNT_LOAD = 4'(GUARD - 1);

    guard_state_e state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (mrst) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ACTIVE: begin
                if (req_change) begin
                    state_d = ST_GUARD;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_GUARD: begin
                // A new mode write restarts the window instead of finishing it.
                if (req_change) begin
                    cnt_d = CNT_LOAD;
                end else if (cnt_q == 4'd0) begin
                    state_d = ST_ACTIVE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_GUARD);
        load_mode = busy && (cnt_q == 4'd0) && !req_change;
    end

endmodule

// File: rtl/memmode_sel.sv
// memmode_sel: selects which of NSRC expansion-bus paging sources drives the
// shared ZX ROM / EEPROM / SRAM control lines, with a ZX-Uno mode register and
// a break-before-make guard window on every source change.
//
// Optional feature: define MODO_DIVFALLBACK_EN to store the fallback-enable
// bit and let source 0 take over while it is paging in (src_zxromcs[0]=0).
//
// Ports
//   clk, mrst                 system clock, synchronous active-high reset
//   zxuno_addr/regrd/regwr    register bus; din write data
//   dout, oe                  registered read data and its one-cycle valid
//   allramplus3               +3 all-RAM mode, parks the outputs
//   src_*                     per-source strobes, bit/slice i = source i
//   zxromcs .. sram_hiaddr    muxed memory controls
module memmode_sel
    import memmode_pkg::*;
#(
    parameter int                    NSRC        = 2,
    parameter int                    HIADDR_W    = 6,
    parameter logic [7:0]            REG_ADDR    = 8'hDF,
    parameter int                    GUARD       = 2,
    parameter logic [HIADDR_W-1:0]   HIADDR_PARK = {PARK_HI_TOP, {(HIADDR_W-2){1'b0}}}
) (
    input  logic                       clk,
    input  logic                       mrst,
    input  logic [7:0]                 zxuno_addr,
    input  logic                       zxuno_regrd,
    input  logic                       zxuno_regwr,
    input  logic [7:0]                 din,
    output logic [7:0]                 dout,
    output logic                       oe,
    input  logic                       allramplus3,
    input  logic [NSRC-1:0]            src_zxromcs,
    input  logic [NSRC-1:0]            src_eeprom_cs,
    input  logic [NSRC-1:0]            src_sram_cs,
    input  logic [NSRC-1:0]            src_sram_write_n,
    input  logic [NSRC*HIADDR_W-1:0]   src_sram_hiaddr,
    output logic                       zxromcs,
    output logic                       eeprom_oe_n,
    output logic                       sram_oe_n,
    output logic                       sram_write_n,
    output logic [HIADDR_W-1:0]        sram_hiaddr
);

    localparam int MW = $clog2(NSRC);

    logic          lock_q, lock_d;
    logic [MW-1:0] mode_req_q, mode_req_d;
    logic [MW-1:0] mode_cur_q, mode_cur_d;
    logic          oe_q, oe_d;
    logic [7:0]    dout_q, dout_d;

    logic          fben;
    logic          fallback;
    logic          wr_ok, mode_ok, req_change, load_mode, busy;
    logic [MW-1:0] din_mode;
    logic [MW-1:0] sel;
    logic [7:0]    reg_rd;
    logic          park;

    assign din_mode   = din[MW-1:0];
    assign wr_ok      = zxuno_regwr && (zxuno_addr == REG_ADDR) && !lock_q;
    assign mode_ok    = wr_ok && (int'(din_mode) < NSRC);
    // Rewriting the current mode in ACTIVE is a no-op; any mode write while
    // parked restarts the window.
    assign req_change = mode_ok && (busy || (din_mode != mode_cur_q));

    memmode_guard #(
        .GUARD (GUARD)
    ) u_guard (
        .clk        (clk),
        .mrst       (mrst),
        .req_change (req_change),
        .load_mode  (load_mode),
        .busy       (busy)
    );

`ifdef MODO_DIVFALLBACK_EN
    logic fben_q, fben_d;
    logic unused_din;

    always_comb begin
        fben_d = fben_q;
        if (wr_ok) fben_d = din[FBEN_BIT];
    end

    always_ff @(posedge clk) begin
        if (mrst) fben_q <= 1'b0;
        else      fben_q <= fben_d;
    end

    assign fben       = fben_q;
    assign fallback   = fben_q && (mode_cur_q != '0) && !src_zxromcs[0];
    assign unused_din = ^{din[BUSY_BIT], din[4:MW]};
`else
    logic unused_din;

    assign fben       = 1'b1;
    assign fallback   = 1'b0;
    assign unused_din = ^{din[FBEN_BIT], din[BUSY_BIT], din[4:MW]};
`endif

    always_comb begin
        reg_rd                = '1;
        reg_rd[LOCK_BIT]      = lock_q;
        reg_rd[FBEN_BIT]      = fben;
        reg_rd[BUSY_BIT]      = busy;
        reg_rd[MW-1:0]        = mode_req_q;
    end

    always_comb begin
        lock_d     = lock_q;
        mode_req_d = mode_req_q;
        mode_cur_d = mode_cur_q;
        if (wr_ok)     lock_d     = din[LOCK_BIT];
        if (mode_ok)   mode_req_d = din_mode;
        if (load_mode) mode_cur_d = mode_req_q;
        // Read captures the pre-write register contents.
        oe_d   = zxuno_regrd && (zxuno_addr == REG_ADDR);
        dout_d = oe_d ? reg_rd : dout_q;
    end

    always_ff @(posedge clk) begin
        if (mrst) begin
            lock_q     <= 1'b0;
            mode_req_q <= '0;
            mode_cur_q <= '0;
            oe_q       <= 1'b0;
            dout_q     <= 8'hFF;
        end else begin
            lock_q     <= lock_d;
            mode_req_q <= mode_req_d;
            mode_cur_q <= mode_cur_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
        end
    end

    assign oe   = oe_q;
    assign dout = dout_q;

    // Output path is purely combinational from registered selection so the
    // strobes see no added latency.
    assign sel  = fallback ? '0 : mode_cur_q;
    assign park = mrst || allramplus3 || busy;

    always_comb begin
        if (park) begin
            zxromcs      = PARK_CTL.zxromcs;
            eeprom_oe_n  = PARK_CTL.eeprom_oe_n;
            sram_oe_n    = PARK_CTL.sram_oe_n;
            sram_write_n = PARK_CTL.sram_write_n;
            sram_hiaddr  = HIADDR_PARK;
        end else begin
            zxromcs      = src_zxromcs[sel];
            eeprom_oe_n  = ~src_eeprom_cs[sel];
            sram_oe_n    = ~src_sram_cs[sel];
            sram_write_n = src_sram_write_n[sel];
            sram_hiaddr  = src_sram_hiaddr[int'(sel)*HIADDR_W +: HIADDR_W];
        end
    end

endmodule
